nr_alu_bist: RTL and testbench
==============================

Name: nr_alu_bist

Overview:
- Synthesizable stimulus/response controller that drives the nanoRisk 8-bit ALU operand/opcode inputs and checks its outputs against an internal reference model.
- Exhaustively sweeps operands and opcodes, counts mismatching vectors and records the first failing vector.
- Sits beside nR_ALU as power-on or debug self-test; the ALU is the responder, this block is the initiator and checker.

Parameters:
OPND_MAX, 3, highest operand value swept on both in0 and in1 (0..255)
OP_MAX, 1, highest opcode swept (legal 0..1; 0=add, 1=sub)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin a run; sampled in IDLE or DONE only
alu_in0  out  8  operand A to ALU
alu_in1  out  8  operand B to ALU
alu_alo  out  4  opcode to ALU
alu_out  in  8  ALU result
alu_zero  in  1  ALU zero flag
alu_ovrflw  in  2  ALU flags: [0]=carry/borrow, [1]=signed overflow
busy  out  1  run in progress
done  out  1  run complete, held until next start or rst
pass  out  1  done and err_count==0
err_count  out  8  failing vectors, saturates at 255
vec_count  out  16  vectors checked this run
first_fail  out  20  {alo[3:0], in0[7:0], in1[7:0]} of first failing vector; 0 if none

Behaviour:
- rst asserted: all outputs 0, FSM to IDLE immediately (asynchronous); also applies mid-run, with no partial result retained.
- FSM states: IDLE, DRIVE, SAMPLE, CHECK, DONE.
- IDLE/DONE + start=1: clear err_count, vec_count, first_fail and done; zero the vector registers; go to DRIVE. start while busy is ignored.
- DRIVE: present the current vector on alu_in0/alu_in1/alu_alo (registered outputs; held stable through SAMPLE and CHECK).
- SAMPLE: register alu_out, alu_zero and alu_ovrflw. The ALU is combinational; one full cycle of settle is guaranteed.
- CHECK: compare the registered ALU outputs with the model. On any mismatch:
  - increment err_count (saturating);
  - capture first_fail if this is the first failure of the run.
  - Always increment vec_count.
- Advance: in0 increments first. At OPND_MAX, in0 wraps to 0 and in1 increments. At OPND_MAX, in1 wraps to 0 and alo increments. After the last vector (in0=in1=OPND_MAX, alo=OP_MAX), go to DONE; otherwise return to DRIVE.
- Throughput: 3 cycles/vector.
  - Vector count = (OPND_MAX+1)^2 x (OP_MAX+1).
  - Default: 32 vectors.
  - done rises 96 cycles after the start-sample edge.
- busy=1 in DRIVE/SAMPLE/CHECK. done=1 only in DONE. pass is combinational from done and err_count.
- Reference model, 8-bit unsigned operands a, b:
  - add: r=(a+b) mod 256; ovrflw[0]=bit 8 of the 9-bit sum; ovrflw[1]=(a7==b7)&&(r7!=a7).
  - sub: r=(a-b) mod 256; ovrflw[0]=(a<b) (borrow); ovrflw[1]=(a7!=b7)&&(r7!=a7).
  - zero=(r==0).
  - A vector fails if any of out, zero or ovrflw differs; it is counted once per vector.
- Counter boundaries:
  - err_count holds at 255.
  - vec_count is wide enough for the maximum of 131072 vectors only if widened. The 16-bit vec_count wraps when OPND_MAX=255, OP_MAX=1; the run still terminates on the vector registers, not on vec_count.

Decomposition:
- Shared package: opcode constants (ALO_ADD=0, ALO_SUB=1), FSM state encoding, flag bit indices (OVF_CARRY=0, OVF_SIGNED=1).
- One natural sub-module: nr_alu_ref_model, a combinational expected-result/flag generator reused by future ALU checkers.

Test Plan:
1. Correct ALU model, defaults, start pulse -> busy for 96 cycles, then done=1, pass=1, err_count=0, vec_count=32, first_fail=0.
2. ALU with out[0] stuck-at-0 (zero derived from the faulty out) -> err_count=16, first_fail={4'd0,8'd1,8'd0}, pass=0.
3. ALU with ovrflw[0] stuck-at-0, defaults -> only sub borrows fail: err_count=6, first_fail={4'd1,8'd0,8'd1}.
4. rst asserted at cycle 40 of a run -> all outputs 0 within the same cycle; a new start then completes normally with vec_count=32.
5. start pulsed at cycle 10 of a run -> ignored, done still at cycle 96. start in DONE -> counters cleared and a new run begins.
6. Inverted-result ALU, OPND_MAX=15, OP_MAX=1 -> vec_count=512, err_count saturates at 255, first_fail={4'd0,8'd0,8'd0}.

Source files
------------

// File: rtl/nr_alu_bist_pkg.sv
// Shared definitions for the nanoRisk ALU self-test controller and its
// reference model: opcode values, flag bit positions and FSM encoding.
package nr_alu_bist_pkg;

    localparam logic [3:0] ALO_ADD = 4'd0;
    localparam logic [3:0] ALO_SUB = 4'd1;

    localparam int OVF_CARRY  = 0;
    localparam int OVF_SIGNED = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Saturating 8-bit increment used for the error counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return 8'hFF;
        end else begin
            return v + 8'd1;
        end
    endfunction

endpackage

// File: rtl/nr_alu_ref_model.sv
// Combinational golden model of the nanoRisk 8-bit ALU: result, zero flag
// and {signed overflow, carry/borrow} flags for add and sub.
module nr_alu_ref_model
    import nr_alu_bist_pkg::*;
(
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic [3:0] i_alo,
    output logic [7:0] o_r,
    output logic       o_zero,
    output logic [1:0] o_ovrflw
);

    logic [8:0] w_sum;
    logic [8:0] w_diff;

    // Bit 8 of the 9-bit sum is the carry; bit 8 of the 9-bit difference
    // is set exactly when a < b, i.e. the borrow.
    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    // Select result and flags by opcode; unknown opcodes yield all-zero.
    always_comb begin
        o_r      = 8'd0;
        o_ovrflw = 2'b00;
        case (i_alo)
            ALO_ADD: begin
                o_r                  = w_sum[7:0];
                o_ovrflw[OVF_CARRY]  = w_sum[8];
                o_ovrflw[OVF_SIGNED] = (i_a[7] == i_b[7]) && (w_sum[7] != i_a[7]);
            end
            ALO_SUB: begin
                o_r                  = w_diff[7:0];
                o_ovrflw[OVF_CARRY]  = w_diff[8];
                o_ovrflw[OVF_SIGNED] = (i_a[7] != i_b[7]) && (w_diff[7] != i_a[7]);
            end
            default: begin
                o_r      = 8'd0;
                o_ovrflw = 2'b00;
            end
        endcase
    end

    assign o_zero = (o_r == 8'd0);

endmodule

// File: rtl/nr_alu_bist.sv
// Self-test initiator/checker for the nanoRisk ALU. Sweeps in0, then in1,
// then the opcode; each vector takes DRIVE, SAMPLE and CHECK cycles.
module nr_alu_bist
    import nr_alu_bist_pkg::*;
#(
    parameter int OPND_MAX = 3,
    parameter int OP_MAX   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  alu_in0,
    output logic [7:0]  alu_in1,
    output logic [3:0]  alu_alo,
    input  logic [7:0]  alu_out,
    input  logic        alu_zero,
    input  logic [1:0]  alu_ovrflw,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  err_count,
    output logic [15:0] vec_count,
    output logic [19:0] first_fail
);

    localparam logic [7:0] LP_OPND_MAX = 8'(OPND_MAX);
    localparam logic [3:0] LP_OP_MAX   = 4'(OP_MAX);

    state_t      r_state;
    logic [7:0]  r_in0;
    logic [7:0]  r_in1;
    logic [3:0]  r_alo;
    logic [7:0]  r_out;
    logic        r_zero;
    logic [1:0]  r_ovrflw;
    logic        r_busy;
    logic        r_done;
    logic [7:0]  r_err_count;
    logic [15:0] r_vec_count;
    logic [19:0] r_first_fail;

    logic [7:0]  w_exp_out;
    logic        w_exp_zero;
    logic [1:0]  w_exp_ovrflw;
    logic        w_mismatch;
    logic        w_in0_last;
    logic        w_in1_last;
    logic        w_alo_last;

    // The vector registers drive the ALU directly and only change when a
    // vector is retired, so they are stable through SAMPLE and CHECK.
    nr_alu_ref_model u_ref (
        .i_a      (r_in0),
        .i_b      (r_in1),
        .i_alo    (r_alo),
        .o_r      (w_exp_out),
        .o_zero   (w_exp_zero),
        .o_ovrflw (w_exp_ovrflw)
    );

    assign w_mismatch = (r_out != w_exp_out) || (r_zero != w_exp_zero) ||
                        (r_ovrflw != w_exp_ovrflw);
    assign w_in0_last = (r_in0 == LP_OPND_MAX);
    assign w_in1_last = (r_in1 == LP_OPND_MAX);
    assign w_alo_last = (r_alo == LP_OP_MAX);

    // Sequencer FSM: run control, response capture, scoring and sweep advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_in0        <= 8'd0;
            r_in1        <= 8'd0;
            r_alo        <= 4'd0;
            r_out        <= 8'd0;
            r_zero       <= 1'b0;
            r_ovrflw     <= 2'b00;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err_count  <= 8'd0;
            r_vec_count  <= 16'd0;
            r_first_fail <= 20'd0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_in0        <= 8'd0;
                        r_in1        <= 8'd0;
                        r_alo        <= 4'd0;
                        r_err_count  <= 8'd0;
                        r_vec_count  <= 16'd0;
                        r_first_fail <= 20'd0;
                        r_done       <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    r_state <= ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    r_out    <= alu_out;
                    r_zero   <= alu_zero;
                    r_ovrflw <= alu_ovrflw;
                    r_state  <= ST_CHECK;
                end
                ST_CHECK: begin
                    r_vec_count <= r_vec_count + 16'd1;
                    if (w_mismatch) begin
                        r_err_count <= sat_inc8(r_err_count);
                        // A zero error count means no earlier failure this run.
                        if (r_err_count == 8'd0) begin
                            r_first_fail <= {r_alo, r_in0, r_in1};
                        end
                    end
                    if (!w_in0_last) begin
                        r_in0   <= r_in0 + 8'd1;
                        r_state <= ST_DRIVE;
                    end else if (!w_in1_last) begin
                        r_in0   <= 8'd0;
                        r_in1   <= r_in1 + 8'd1;
                        r_state <= ST_DRIVE;
                    end else if (!w_alo_last) begin
                        r_in0   <= 8'd0;
                        r_in1   <= 8'd0;
                        r_alo   <= r_alo + 4'd1;
                        r_state <= ST_DRIVE;
                    end else begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign alu_in0    = r_in0;
    assign alu_in1    = r_in1;
    assign alu_alo    = r_alo;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err_count  = r_err_count;
    assign vec_count  = r_vec_count;
    assign first_fail = r_first_fail;
    assign pass       = r_done && (r_err_count == 8'd0);

endmodule

// File: tb/tb_nr_alu_bist.sv
// Directed testbench for nr_alu_bist: a behavioural ALU responder with
// selectable faults, plus a wider-sweep instance for counter saturation.
module tb_nr_alu_bist;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic start2;

    always #5 clk = ~clk;

    // DUT 1 (defaults) signals
    logic [7:0]  alu_in0, alu_in1, alu_out;
    logic [3:0]  alu_alo;
    logic        alu_zero;
    logic [1:0]  alu_ovrflw;
    logic        busy, done, pass;
    logic [7:0]  err_count;
    logic [15:0] vec_count;
    logic [19:0] first_fail;

    // DUT 2 (OPND_MAX=15) signals
    logic [7:0]  alu_in0_2, alu_in1_2, alu_out_2;
    logic [3:0]  alu_alo_2;
    logic        alu_zero_2;
    logic [1:0]  alu_ovrflw_2;
    logic        busy_2, done_2, pass_2;
    logic [7:0]  err_count_2;
    logic [15:0] vec_count_2;
    logic [19:0] first_fail_2;

    // Reference model direct-test signals
    logic [7:0] rm_a, rm_b, rm_r;
    logic [3:0] rm_alo;
    logic       rm_zero;
    logic [1:0] rm_ovf;

    int fault_mode;
    int n_checks = 0;
    int n_fail   = 0;

    nr_alu_bist u_dut (
        .clk(clk), .rst(rst), .start(start),
        .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_alo(alu_alo),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_ovrflw(alu_ovrflw),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .vec_count(vec_count), .first_fail(first_fail)
    );

    nr_alu_bist #(.OPND_MAX(15), .OP_MAX(1)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2),
        .alu_in0(alu_in0_2), .alu_in1(alu_in1_2), .alu_alo(alu_alo_2),
        .alu_out(alu_out_2), .alu_zero(alu_zero_2), .alu_ovrflw(alu_ovrflw_2),
        .busy(busy_2), .done(done_2), .pass(pass_2),
        .err_count(err_count_2), .vec_count(vec_count_2), .first_fail(first_fail_2)
    );

    nr_alu_ref_model u_rm (
        .i_a(rm_a), .i_b(rm_b), .i_alo(rm_alo),
        .o_r(rm_r), .o_zero(rm_zero), .o_ovrflw(rm_ovf)
    );

    // Behavioural ALU responder for DUT 1 with fault injection.
    logic [8:0] t1;
    logic       sgn1;
    assign t1   = (alu_alo == 4'd1) ? ({1'b0, alu_in0} - {1'b0, alu_in1})
                                    : ({1'b0, alu_in0} + {1'b0, alu_in1});
    assign sgn1 = (alu_alo == 4'd1) ? ((alu_in0[7] != alu_in1[7]) && (t1[7] != alu_in0[7]))
                                    : ((alu_in0[7] == alu_in1[7]) && (t1[7] != alu_in0[7]));
    assign alu_out    = (fault_mode == 1) ? {t1[7:1], 1'b0} : t1[7:0];
    assign alu_zero   = (alu_out == 8'd0);
    assign alu_ovrflw = {sgn1, (fault_mode == 2) ? 1'b0 : t1[8]};

    // Result-inverting ALU responder for DUT 2.
    logic [8:0] t2;
    assign t2 = (alu_alo_2 == 4'd1) ? ({1'b0, alu_in0_2} - {1'b0, alu_in1_2})
                                    : ({1'b0, alu_in0_2} + {1'b0, alu_in1_2});
    assign alu_out_2    = ~t2[7:0];
    assign alu_zero_2   = (alu_out_2 == 8'd0);
    assign alu_ovrflw_2 = {1'b0, t2[8]};

    task automatic kick();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cyc, output bit busy_ok);
        cyc = 0;
        busy_ok = 1'b1;
        while (!done && cyc < limit) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start2 = 1'b0; fault_mode = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n_checks++; if ({busy, done, pass} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {busy, done, pass}); end
        n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL reset_err: got %0d expected 0", err_count); end
        n_checks++; if (vec_count !== 16'd0) begin n_fail++; $display("FAIL reset_vec: got %0d expected 0", vec_count); end
        n_checks++; if (first_fail !== 20'd0) begin n_fail++; $display("FAIL reset_ff: got %h expected 0", first_fail); end
        n_checks++; if ({alu_in0, alu_in1, alu_alo} !== 20'd0) begin n_fail++; $display("FAIL reset_vec_regs: got %h expected 0", {alu_in0, alu_in1, alu_alo}); end
    endtask

    task automatic test_ref_model();
        logic [3:0]  alo_v [7] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1};
        logic [7:0]  a_v   [7] = '{8'd127, 8'd200, 8'd128, 8'd128, 8'd5, 8'd9, 8'd1};
        logic [7:0]  b_v   [7] = '{8'd1, 8'd100, 8'd128, 8'd1, 8'd7, 8'd9, 8'd128};
        logic [7:0]  r_v   [7] = '{8'd128, 8'd44, 8'd0, 8'd127, 8'd254, 8'd0, 8'd129};
        logic        z_v   [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [1:0]  f_v   [7] = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b01, 2'b00, 2'b11};
        for (int i = 0; i < 7; i++) begin
            rm_alo = alo_v[i]; rm_a = a_v[i]; rm_b = b_v[i];
            #1;
            n_checks++;
            if ({rm_r, rm_zero, rm_ovf} !== {r_v[i], z_v[i], f_v[i]}) begin
                n_fail++;
                $display("FAIL ref_model[%0d]: got r=%0d z=%b f=%b expected r=%0d z=%b f=%b",
                         i, rm_r, rm_zero, rm_ovf, r_v[i], z_v[i], f_v[i]);
            end
        end
    endtask

    task automatic test_good_run();
        int cyc; bit bok;
        fault_mode = 0;
        kick();
        wait_done(2000, cyc, bok);
        n_checks++; if (cyc !== 96) begin n_fail++; $display("FAIL good_latency: got %0d expected 96", cyc); end
        n_checks++; if (!bok) begin n_fail++; $display("FAIL good_busy: got busy low during run expected high"); end
        n_checks++; if ({busy, done, pass} !== 3'b011) begin n_fail++; $display("FAIL good_flags: got %b expected 011", {busy, done, pass}); end
        n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL good_err: got %0d expected 0", err_count); end
        n_checks++; if (vec_count !== 16'd32) begin n_fail++; $display("FAIL good_vec: got %0d expected 32", vec_count); end
        n_checks++; if (first_fail !== 20'd0) begin n_fail++; $display("FAIL good_ff: got %h expected 0", first_fail); end
    endtask

    task automatic test_out0_stuck();
        int cyc; bit bok;
        fault_mode = 1;
        kick();
        wait_done(2000, cyc, bok);
        n_checks++; if (err_count !== 8'd16) begin n_fail++; $display("FAIL out0_err: got %0d expected 16", err_count); end
        n_checks++; if (first_fail !== {4'd0, 8'd1, 8'd0}) begin n_fail++; $display("FAIL out0_ff: got %h expected %h", first_fail, {4'd0, 8'd1, 8'd0}); end
        n_checks++; if ({done, pass} !== 2'b10) begin n_fail++; $display("FAIL out0_pass: got %b expected 10", {done, pass}); end
        n_checks++; if (vec_count !== 16'd32) begin n_fail++; $display("FAIL out0_vec: got %0d expected 32", vec_count); end
    endtask

    task automatic test_carry_stuck();
        int cyc; bit bok;
        fault_mode = 2;
        kick();
        wait_done(2000, cyc, bok);
        n_checks++; if (err_count !== 8'd6) begin n_fail++; $display("FAIL carry_err: got %0d expected 6", err_count); end
        n_checks++; if (first_fail !== {4'd1, 8'd0, 8'd1}) begin n_fail++; $display("FAIL carry_ff: got %h expected %h", first_fail, {4'd1, 8'd0, 8'd1}); end
        n_checks++; if (pass !== 1'b0) begin n_fail++; $display("FAIL carry_pass: got %b expected 0", pass); end
    endtask

    task automatic test_reset_midrun();
        int cyc; bit bok;
        fault_mode = 1;
        kick();
        repeat (40) @(posedge clk);
        #1;
        n_checks++; if ({busy, err_count, vec_count} !== {1'b1, 8'd7, 16'd13}) begin n_fail++; $display("FAIL mid_state: got busy=%b err=%0d vec=%0d expected 1/7/13", busy, err_count, vec_count); end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, pass, err_count, vec_count, first_fail, alu_in0, alu_in1, alu_alo} !== 75'd0) begin
            n_fail++;
            $display("FAIL mid_rst_clear: got busy=%b done=%b err=%0d vec=%0d ff=%h expected all 0", busy, done, err_count, vec_count, first_fail);
        end
        @(posedge clk); #1 rst = 1'b0;
        fault_mode = 0;
        kick();
        wait_done(2000, cyc, bok);
        n_checks++; if ({cyc, vec_count, pass} !== {32'd96, 16'd32, 1'b1}) begin n_fail++; $display("FAIL mid_rerun: got cyc=%0d vec=%0d pass=%b expected 96/32/1", cyc, vec_count, pass); end
    endtask

    task automatic test_start_ignored();
        int cyc; bit bok;
        fault_mode = 1;
        kick();
        cyc = 0;
        while (!done && cyc < 2000) begin
            start = (cyc == 9);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        n_checks++; if (cyc !== 96) begin n_fail++; $display("FAIL ign_latency: got %0d expected 96", cyc); end
        n_checks++; if ({vec_count, err_count} !== {16'd32, 8'd16}) begin n_fail++; $display("FAIL ign_counts: got vec=%0d err=%0d expected 32/16", vec_count, err_count); end
        fault_mode = 0;
        kick();
        n_checks++;
        if ({busy, done, err_count, vec_count, first_fail} !== {1'b1, 1'b0, 8'd0, 16'd0, 20'd0}) begin
            n_fail++;
            $display("FAIL restart_clear: got busy=%b done=%b err=%0d vec=%0d ff=%h expected 1/0/0/0/0", busy, done, err_count, vec_count, first_fail);
        end
        wait_done(2000, cyc, bok);
        n_checks++; if ({cyc, pass} !== {32'd96, 1'b1}) begin n_fail++; $display("FAIL restart_run: got cyc=%0d pass=%b expected 96/1", cyc, pass); end
    endtask

    task automatic test_saturate();
        int cyc;
        @(posedge clk); #1 start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        cyc = 0;
        while (!done_2 && cyc < 5000) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_checks++; if (cyc !== 1536) begin n_fail++; $display("FAIL sat_latency: got %0d expected 1536", cyc); end
        n_checks++; if (vec_count_2 !== 16'd512) begin n_fail++; $display("FAIL sat_vec: got %0d expected 512", vec_count_2); end
        n_checks++; if (err_count_2 !== 8'd255) begin n_fail++; $display("FAIL sat_err: got %0d expected 255", err_count_2); end
        n_checks++; if (first_fail_2 !== 20'd0) begin n_fail++; $display("FAIL sat_ff: got %h expected 0", first_fail_2); end
        n_checks++; if (pass_2 !== 1'b0) begin n_fail++; $display("FAIL sat_pass: got %b expected 0", pass_2); end
    endtask

    initial begin
        rm_a = 8'd0; rm_b = 8'd0; rm_alo = 4'd0;
        test_reset();
        test_ref_model();
        test_good_run();
        test_out0_stuck();
        test_carry_stuck();
        test_reset_midrun();
        test_start_ignored();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
